timer_int_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the timer subsystem. It collects per-channel compare `match` events into sticky status bits, tracks overrun, and produces one combined timer interrupt. It also reports the lowest-index pending channel, so firmware can service the interrupt without scanning every channel. It sits between the timer compare channels and the system interrupt line, with clear and enable strobes driven from the register block.

---
 rtl/timer_int_ctrl.sv | 61 ++++++
 tb/tb_timer_int_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_int_ctrl.sv
// timer_int_ctrl: sticky per-channel timer interrupt status with overrun tracking,
// lowest-index pending id and a level or stretched-pulse combined interrupt.
module timer_int_ctrl #(
  parameter int NUM_CH = 4,
  parameter int PULSE_MODE = 0,
  parameter int PULSE_W = 2,
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] match,
  input  logic [NUM_CH-1:0] int_en,
  input  logic [NUM_CH-1:0] edge_mode,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] int_st,
  output logic [NUM_CH-1:0] int_ovf,
  output logic              int_vld,
  output logic [ID_W-1:0]   int_id,
  output logic              tim_int
);
  localparam int CW = $clog2(PULSE_W + 1);
  logic [NUM_CH-1:0] match_q, st_q, st_d, ovf_q, ovf_d, set;
  logic              vld_q, vld_d, trig_q, trig_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  always_comb begin
    set = int_en & ((edge_mode & match & ~match_q) | (~edge_mode & match));
    st_d = int_en & (set | (st_q & ~clear));
    ovf_d = int_en & ~clear & (ovf_q | (set & st_q));
    vld_d = |st_q;
    id_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (st_q[i]) id_d = ID_W'(i);
    // any channel newly pending (re)starts the pulse one cycle later, aligned with int_vld
    trig_d = |(st_d & ~st_q);
    cnt_d = trig_q ? CW'(PULSE_W) : (cnt_q != '0) ? cnt_q - CW'(1) : '0;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      match_q <= '0;
      st_q    <= '0;
      ovf_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= match;
      st_q    <= st_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
    end
  end
  assign int_st  = st_q;
  assign int_ovf = ovf_q;
  assign int_vld = vld_q;
  assign int_id  = id_q;
  assign tim_int = (PULSE_MODE != 0) ? (cnt_q != '0) : vld_q;
endmodule

// File: tb/tb_timer_int_ctrl.sv
// tb_timer_int_ctrl: random and directed stimulus on a level-mode and a pulse-mode instance,
// expected outputs from a behavioural model queued per edge and checked by a monitor.
module tb_timer_int_ctrl;
  localparam int N = 4;
  localparam int PW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] match = '0, en = '0, em = '0, clr = '0;
  logic [N-1:0] l_st, l_ovf, p_st, p_ovf;
  logic l_vld, l_tim, p_vld, p_tim;
  logic [1:0] l_id, p_id;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [N-1:0] st, ovf;
    logic vld, tim_l, tim_p;
    logic [1:0] id;
  } exp_t;
  exp_t q[$];

  bit m_st[N], m_ovf[N], m_prev[N];
  int edge_no = 0, last_trig = -1000;

  always #5 clk = ~clk;

  timer_int_ctrl #(.NUM_CH(N), .PULSE_MODE(0), .PULSE_W(2)) u_lvl (
    .sys_clk(clk), .sys_rst(rst), .match(match), .int_en(en), .edge_mode(em), .clear(clr),
    .int_st(l_st), .int_ovf(l_ovf), .int_vld(l_vld), .int_id(l_id), .tim_int(l_tim));
  timer_int_ctrl #(.NUM_CH(N), .PULSE_MODE(1), .PULSE_W(PW)) u_pls (
    .sys_clk(clk), .sys_rst(rst), .match(match), .int_en(en), .edge_mode(em), .clear(clr),
    .int_st(p_st), .int_ovf(p_ovf), .int_vld(p_vld), .int_id(p_id), .tim_int(p_tim));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_ovf[i] = 0;
      m_prev[i] = 0;
    end
    last_trig = -1000;
  endtask

  // Applies the channel priority rules to the inputs seen at one rising edge.
  task automatic model_edge();
    exp_t e;
    bit old_st[N];
    bit s, newly;
    edge_no++;
    old_st = m_st;
    newly = 0;
    for (int i = 0; i < N; i++) begin
      s = en[i] && (em[i] ? (match[i] && !m_prev[i]) : match[i]);
      if (!en[i]) begin m_st[i] = 0; m_ovf[i] = 0; end
      else if (clr[i] && s) begin m_st[i] = 1; m_ovf[i] = 0; end
      else if (clr[i]) begin m_st[i] = 0; m_ovf[i] = 0; end
      else if (s && m_st[i]) m_ovf[i] = 1;
      else if (s) m_st[i] = 1;
      m_prev[i] = match[i];
      if (m_st[i] && !old_st[i]) newly = 1;
    end
    e.vld = 0;
    e.id = 0;
    for (int i = N - 1; i >= 0; i--) if (old_st[i]) begin e.vld = 1; e.id = 2'(i); end
    e.tim_l = e.vld;
    e.tim_p = (edge_no > last_trig) && (edge_no <= last_trig + PW);
    if (newly) last_trig = edge_no;
    for (int i = 0; i < N; i++) begin
      e.st[i] = m_st[i];
      e.ovf[i] = m_ovf[i];
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic [N-1:0] m, input logic [N-1:0] e, input logic [N-1:0] md,
                     input logic [N-1:0] c);
    @(negedge clk);
    #1;
    match = m; en = e; em = md; clr = c;
    @(posedge clk);
    model_edge();
  endtask

  task automatic async_reset(input logic [N-1:0] m_rel, input logic [N-1:0] em_rel);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_st", {28'd0, l_st}, 32'd0);
    check("rst_ovf", {28'd0, l_ovf}, 32'd0);
    check("rst_vld", {31'd0, l_vld}, 32'd0);
    check("rst_id", {30'd0, l_id}, 32'd0);
    check("rst_tim_l", {31'd0, l_tim}, 32'd0);
    check("rst_tim_p", {31'd0, p_tim}, 32'd0);
    check("rst_st_p", {28'd0, p_st}, 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    match = m_rel; en = 4'hF; em = em_rel; clr = '0;
    rst = 1'b0;
    @(posedge clk);
    model_edge();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        check("st", {28'd0, l_st}, {28'd0, e.st});
        check("ovf", {28'd0, l_ovf}, {28'd0, e.ovf});
        check("vld", {31'd0, l_vld}, {31'd0, e.vld});
        check("id", {30'd0, l_id}, {30'd0, e.id});
        check("tim_level", {31'd0, l_tim}, {31'd0, e.tim_l});
        check("tim_pulse", {31'd0, p_tim}, {31'd0, e.tim_p});
        check("st_pulse", {28'd0, p_st}, {28'd0, e.st});
      end
    end
  end

  initial begin : stim
    logic [N-1:0] md;
    model_reset();
    #12 rst = 1'b0;
    // single level-mode match, then clear
    for (int k = 0; k < 3; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    cyc(4'b0100, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'b0100);
    for (int k = 0; k < 5; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    // overrun on ch0, then clear colliding with a new rising edge
    cyc(4'h1, 4'hF, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'hF, 4'h0);
    cyc(4'h1, 4'hF, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'hF, 4'h0);
    cyc(4'h1, 4'hF, 4'hF, 4'h1);
    cyc(4'h0, 4'hF, 4'hF, 4'hF);
    for (int k = 0; k < 5; k++) cyc(4'h0, 4'hF, 4'hF, 4'h0);
    // priority id, then clear ch1 to expose ch3
    cyc(4'b1010, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'b0010);
    for (int k = 0; k < 5; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'hF);
    // held match in edge mode, disable, re-enable while still high
    for (int k = 0; k < 4; k++) cyc(4'h8, 4'hF, 4'hF, 4'h0);
    cyc(4'h8, 4'h7, 4'hF, 4'h0);
    cyc(4'h8, 4'h7, 4'hF, 4'h0);
    for (int k = 0; k < 4; k++) cyc(4'h8, 4'hF, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'hF, 4'hF);
    for (int k = 0; k < 6; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    // pulse stretch: ch0 then ch2 one cycle into the pulse
    cyc(4'h1, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'h0);
    cyc(4'h4, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 8; k++) cyc(4'h0, 4'hF, 4'h0, 4'h0);
    // async reset mid-pulse with all channels pending, release with match[0] high in edge mode
    cyc(4'hF, 4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0, 4'h0);
    async_reset(4'h1, 4'h1);
    for (int k = 0; k < 4; k++) cyc(4'h1, 4'hF, 4'h1, 4'h0);
    // randomized traffic
    md = 4'($urandom);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) md = 4'($urandom);
      cyc(4'($urandom) & 4'($urandom),
          ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF,
          md,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) & 4'($urandom) : 4'h0);
      if (k == 1500) async_reset(4'($urandom), 4'($urandom));
    end
    cyc(4'h0, 4'hF, 4'h0, 4'h0);
    @(negedge clk);
    #1;
    if (q.size() != 0) check("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
